shared_compare_sched: RTL and testbench

Time-multiplexed equality-compare engine shared among NREQ requesters. A round-robin arbiter grants one request at a time. The winner's two WIDTH-bit operands are compared CHUNK bits per cycle on a single carry-chain wide-AND slice, with early exit on the first mismatching chunk. It sits between tag/key lookup clients and replaces NREQ full-width comparators with one narrow one.

---
 rtl/shared_compare_sched_pkg.sv | 22 ++
 rtl/shared_compare_sched_chunk_eq.sv | 29 ++
 rtl/shared_compare_sched.sv | 132 +++++++++++++
 tb/tb_shared_compare_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_compare_sched_pkg.sv
// Shared types and elaboration-time helpers for the time-multiplexed compare engine.
package cmp_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned calc_nchunk(input int unsigned w, input int unsigned c);
    return (w + c - 1) / c;
  endfunction

  // Index width that never collapses to zero bits, even for a single entry.
  function automatic int unsigned calc_idw(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/shared_compare_sched_chunk_eq.sv
// One CHUNK-bit equality slice: per-bit XNOR reduced by a 3-input-per-cell AND chain.
module chunk_eq #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             eq
);

  localparam int unsigned NCELL = (CHUNK + 2) / 3;

  logic [3*NCELL-1:0] bit_eq;
  logic [NCELL:0]     carry;

  // Unused cell inputs are tied high so a partial last cell is transparent.
  always_comb begin
    bit_eq             = '1;
    bit_eq[CHUNK-1:0]  = ~(a_i ^ b_i);
  end

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < NCELL; i++) begin : g_cell
    assign carry[i+1] = carry[i] & bit_eq[3*i] & bit_eq[3*i+1] & bit_eq[3*i+2];
  end

  assign eq = carry[NCELL];

endmodule

// File: rtl/shared_compare_sched.sv
// Round-robin shared equality comparator: one winner at a time, CHUNK bits per cycle, early exit.
module shared_compare_sched
  import cmp_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16,
  parameter int unsigned NREQ  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*WIDTH-1:0]         req_a,
  input  logic [NREQ*WIDTH-1:0]         req_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [calc_idw(NREQ)-1:0]     res_id,
  output logic                          res_equal,
  output logic                          busy
);

  localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned IDW    = calc_idw(NREQ);
  localparam int unsigned IDXW   = calc_idw(NCHUNK);
  localparam int unsigned PADW   = NCHUNK * CHUNK;

  state_e            state_q;
  logic [IDW-1:0]    last_grant_q;
  logic [IDW-1:0]    cur_id_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  op_a_q;
  logic [WIDTH-1:0]  op_b_q;
  logic              res_valid_q;
  logic              res_equal_q;

  logic [2*NREQ-1:0] dbl_valid;
  int unsigned       rr_start;
  logic              grant_any;
  logic [IDW-1:0]    grant_idx;
  logic [NREQ-1:0]   grant_oh;

  // Scanning the doubled vector from the rotation point covers the wrap-around in one pass.
  always_comb begin
    dbl_valid = {req_valid, req_valid};
    rr_start  = (32'(last_grant_q) + 32'd1) % NREQ;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int unsigned p = 0; p < 2*NREQ; p++) begin
      if (!grant_any && p >= rr_start && dbl_valid[p]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(p % NREQ);
      end
    end
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  assign req_ready = grant_oh & {NREQ{(state_q == IDLE) && !rst}};

  logic [PADW-1:0]  pad_a;
  logic [PADW-1:0]  pad_b;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             chunk_match;

  // Padding bits are zero on both sides so they always compare equal.
  always_comb begin
    pad_a              = '0;
    pad_b              = '0;
    pad_a[WIDTH-1:0]   = op_a_q;
    pad_b[WIDTH-1:0]   = op_b_q;
    chunk_a            = pad_a[idx_q*CHUNK +: CHUNK];
    chunk_b            = pad_b[idx_q*CHUNK +: CHUNK];
  end

  chunk_eq #(
    .CHUNK (CHUNK)
  ) u_chunk_eq (
    .a_i (chunk_a),
    .b_i (chunk_b),
    .eq  (chunk_match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      cur_id_q     <= '0;
      res_valid_q  <= 1'b0;
      res_equal_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            op_a_q       <= req_a[grant_idx*WIDTH +: WIDTH];
            op_b_q       <= req_b[grant_idx*WIDTH +: WIDTH];
            cur_id_q     <= grant_idx;
            last_grant_q <= grant_idx;
            idx_q        <= '0;
            state_q      <= RUN;
          end
        end
        RUN: begin
          if (!chunk_match) begin
            res_equal_q <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (idx_q == IDXW'(NCHUNK - 1)) begin
            res_equal_q <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_equal = res_equal_q;
  assign res_id    = cur_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shared_compare_sched.sv
// Randomised and directed checks of shared_compare_sched against a chunk-scan reference model.
module tb_shared_compare_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready;
  logic [255:0] req_a, req_b;
  logic         res_valid, res_ready, res_equal, busy;
  logic [1:0]   res_id;

  logic [3:0]   v40, rdy40;
  logic [159:0] a40, b40;
  logic         rv40, eq40, busy40;
  logic [1:0]   rid40;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  shared_compare_sched #(.WIDTH(64), .CHUNK(16), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_equal(res_equal), .busy(busy)
  );

  shared_compare_sched #(.WIDTH(40), .CHUNK(16), .NREQ(4)) dut40 (
    .clk(clk), .rst(rst), .req_valid(v40), .req_ready(rdy40),
    .req_a(a40), .req_b(b40), .res_valid(rv40), .res_ready(res_ready),
    .res_id(rid40), .res_equal(eq40), .busy(busy40)
  );

  // Reference: cycles from transfer to first res_valid = (1-based first differing chunk, or NCHUNK) + 1.
  function automatic int exp_lat(input logic [63:0] a, input logic [63:0] b, input int width, input int chunk);
    logic [63:0] d;
    int nch;
    d = a ^ b;
    if (width < 64) d = d & ((64'd1 << width) - 64'd1);
    nch = (width + chunk - 1) / chunk;
    for (int c = 0; c < nch; c++)
      if (((d >> (c*chunk)) & ((64'd1 << chunk) - 64'd1)) != 64'd0) return c + 2;
    return nch + 1;
  endfunction

  function automatic logic exp_eq(input logic [63:0] a, input logic [63:0] b, input int width);
    logic [63:0] d;
    d = a ^ b;
    if (width < 64) d = d & ((64'd1 << width) - 64'd1);
    return d == 64'd0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; v40 = '0; res_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input bit w40, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if ((w40 ? busy40 : busy) === 1'b0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  // Single request on one requester; measures latency from the transfer cycle.
  task automatic run_op(input bit w40, input int r, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output logic eq, output int id, output bit busy_ok, output bit ok);
    lat = 0; eq = 1'b0; id = -1; busy_ok = 1'b1; ok = 1'b0;
    if (w40) begin
      a40[r*40 +: 40] = a[39:0]; b40[r*40 +: 40] = b[39:0]; v40 = 4'(1 << r);
    end else begin
      req_a[r*64 +: 64] = a; req_b[r*64 +: 64] = b; req_valid = 4'(1 << r);
    end
    for (int c = 0; c < 20; c++) begin
      #1;
      if ((w40 ? rdy40[r] : req_ready[r]) === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = '0; v40 = '0;
    if (!ok) return;
    ok = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      lat = c;
      if ((w40 ? busy40 : busy) !== 1'b1) busy_ok = 1'b0;
      if ((w40 ? rv40 : res_valid) === 1'b1) begin
        ok = 1'b1;
        eq = w40 ? eq40 : res_equal;
        id = int'(w40 ? rid40 : res_id);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; v40 = 4'hF; res_ready = 1'b1;
    req_a = '0; req_b = '0; a40 = '0; b40 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1; #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready); else n_pass++;
    n_checks++; if (rdy40 !== 4'b0000) $display("FAIL reset_ready40: got %b expected 0000", rdy40); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b expected 0", res_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (res_id !== 2'd0) $display("FAIL reset_res_id: got %0d expected 0", res_id); else n_pass++;
    n_checks++; if (res_equal !== 1'b0) $display("FAIL reset_res_equal: got %b expected 0", res_equal); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b expected 0001", req_ready); else n_pass++;
    req_valid = '0; v40 = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int lat, id; logic eq; bit bok, ok;
    logic [63:0] a;
    do_reset();
    a = 64'hDEAD_BEEF_0123_4567;
    run_op(1'b0, 1, a, a, lat, eq, id, bok, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL single_timeout: got %b expected 1", ok); else n_pass++;
    n_checks++; if (lat !== exp_lat(a, a, 64, 16)) $display("FAIL single_latency: got %0d expected %0d", lat, exp_lat(a, a, 64, 16)); else n_pass++;
    n_checks++; if (eq !== 1'b1) $display("FAIL single_equal: got %b expected 1", eq); else n_pass++;
    n_checks++; if (id !== 1) $display("FAIL single_id: got %0d expected 1", id); else n_pass++;
    n_checks++; if (bok !== 1'b1) $display("FAIL single_busy_window: got %b expected 1", bok); else n_pass++;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_after: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_early_exit();
    int lat, id; logic eq; bit bok, ok;
    logic [63:0] bs [2];
    bs[0] = 64'h1;
    bs[1] = 64'h0000_0100_0000_0000;
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, 0, 64'h0, bs[i], lat, eq, id, bok, ok);
      n_checks++; if (ok !== 1'b1 || lat !== exp_lat(64'h0, bs[i], 64, 16))
        $display("FAIL early_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(64'h0, bs[i], 64, 16)); else n_pass++;
      n_checks++; if (eq !== 1'b0) $display("FAIL early_equal[%0d]: got %b expected 0", i, eq); else n_pass++;
    end
  endtask

  task automatic test_random();
    int lat, id, r, mode; logic eq; bit bok, ok;
    logic [63:0] a, b;
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 2));
      a = {$urandom, $urandom};
      if (mode == 0) b = a;
      else if (mode == 1) b = a ^ (64'd1 << $urandom_range(0, 63));
      else b = {$urandom, $urandom};
      run_op(1'b0, r, a, b, lat, eq, id, bok, ok);
      n_checks++; if (ok !== 1'b1 || lat !== exp_lat(a, b, 64, 16))
        $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(a, b, 64, 16)); else n_pass++;
      n_checks++; if (eq !== exp_eq(a, b, 64)) $display("FAIL rand_equal[%0d]: got %b expected %b", i, eq, exp_eq(a, b, 64)); else n_pass++;
      n_checks++; if (id !== r) $display("FAIL rand_id[%0d]: got %0d expected %0d", i, id, r); else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    int last, ng, prev_c;
    bit ok;
    logic [3:0] exp_oh;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      req_a[r*64 +: 64] = 64'h0123_4567_89AB_CDEF;
      req_b[r*64 +: 64] = 64'h0123_4567_89AB_CDEF;
    end
    req_valid = 4'hF;
    last = 3; ng = 0; prev_c = -1;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      #1;
      if (req_ready !== 4'b0000) begin
        exp_oh = 4'(1 << ((last + 1) % 4));
        n_checks++; if (req_ready !== exp_oh) $display("FAIL rr_grant[%0d]: got %b expected %b", ng, req_ready, exp_oh); else n_pass++;
        if (prev_c >= 0) begin
          n_checks++; if (c - prev_c !== 6) $display("FAIL rr_interval[%0d]: got %0d expected 6", ng, c - prev_c); else n_pass++;
        end
        last = (last + 1) % 4; prev_c = c; ng++;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    n_checks++; if (ng !== 5) $display("FAIL rr_grant_count: got %0d expected 5", ng); else n_pass++;
    drain(1'b0, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rr_drain: got %b expected 1", ok); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit got, stable, noready, ok;
    logic [1:0] id0; logic eq0;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      req_a[r*64 +: 64] = 64'hFACE_0000_1111_2222;
      req_b[r*64 +: 64] = 64'hFACE_0000_1111_2222;
    end
    req_valid = 4'hF; res_ready = 1'b0;
    got = 1'b0; id0 = '0; eq0 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (res_valid === 1'b1) begin got = 1'b1; id0 = res_id; eq0 = res_equal; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (got !== 1'b1) $display("FAIL bp_result_timeout: got %b expected 1", got); else n_pass++;
    n_checks++; if (id0 !== 2'd0) $display("FAIL bp_first_id: got %0d expected 0", id0); else n_pass++;
    n_checks++; if (eq0 !== 1'b1) $display("FAIL bp_first_equal: got %b expected 1", eq0); else n_pass++;
    stable = 1'b1; noready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1; #1;
      if (res_valid !== 1'b1 || res_id !== id0 || res_equal !== eq0) stable = 1'b0;
      if (req_ready !== 4'b0000) noready = 1'b0;
    end
    n_checks++; if (stable !== 1'b1) $display("FAIL bp_stable: got %b expected 1", stable); else n_pass++;
    n_checks++; if (noready !== 1'b1) $display("FAIL bp_no_ready: got %b expected 1", noready); else n_pass++;
    @(posedge clk); #1;
    res_ready = 1'b1;
    #1;
    n_checks++; if (res_valid !== 1'b1) $display("FAIL bp_valid_at_release: got %b expected 1", res_valid); else n_pass++;
    @(posedge clk); #1; #1;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL bp_resume_grant: got %b expected 0010", req_ready); else n_pass++;
    req_valid = '0;
    drain(1'b0, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL bp_drain: got %b expected 1", ok); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    bit nores, ok;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      req_a[r*64 +: 64] = 64'h5555_AAAA_5555_AAAA;
      req_b[r*64 +: 64] = 64'h5555_AAAA_5555_AAAA;
    end
    req_valid = 4'b1010;
    #1;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL mr_first_grant: got %b expected 0010", req_ready); else n_pass++;
    nores = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1; #1;
      if (res_valid !== 1'b0) nores = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    if (res_valid !== 1'b0) nores = 1'b0;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL mr_ready_in_reset: got %b expected 0000", req_ready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (nores !== 1'b1) $display("FAIL mr_no_result: got %b expected 1", nores); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL mr_res_valid: got %b expected 0", res_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mr_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (res_id !== 2'd0) $display("FAIL mr_res_id: got %0d expected 0", res_id); else n_pass++;
    n_checks++; if (res_equal !== 1'b0) $display("FAIL mr_res_equal: got %b expected 0", res_equal); else n_pass++;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL mr_regrant: got %b expected 0010", req_ready); else n_pass++;
    @(posedge clk); #1;
    req_valid = '0;
    drain(1'b0, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL mr_drain: got %b expected 1", ok); else n_pass++;
  endtask

  task automatic test_width40();
    int lat, id; logic eq; bit bok, ok;
    logic [63:0] a, b;
    do_reset();
    a = 64'h0000_00AB_CDEF_0123;
    run_op(1'b1, 0, a, a, lat, eq, id, bok, ok);
    n_checks++; if (ok !== 1'b1 || lat !== exp_lat(a, a, 40, 16))
      $display("FAIL w40_eq_latency: got %0d expected %0d", lat, exp_lat(a, a, 40, 16)); else n_pass++;
    n_checks++; if (eq !== 1'b1) $display("FAIL w40_eq_equal: got %b expected 1", eq); else n_pass++;
    b = a ^ (64'd1 << 39);
    run_op(1'b1, 0, a, b, lat, eq, id, bok, ok);
    n_checks++; if (ok !== 1'b1 || lat !== exp_lat(a, b, 40, 16))
      $display("FAIL w40_ne_latency: got %0d expected %0d", lat, exp_lat(a, b, 40, 16)); else n_pass++;
    n_checks++; if (eq !== 1'b0) $display("FAIL w40_ne_equal: got %b expected 0", eq); else n_pass++;
    b = {$urandom, $urandom};
    b[63:40] = '0;
    run_op(1'b1, 2, a, b, lat, eq, id, bok, ok);
    n_checks++; if (ok !== 1'b1 || lat !== exp_lat(a, b, 40, 16) || eq !== exp_eq(a, b, 40) || id !== 2)
      $display("FAIL w40_rand: got lat %0d eq %b id %0d expected lat %0d eq %b id 2", lat, eq, id, exp_lat(a, b, 40, 16), exp_eq(a, b, 40)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_early_exit();
    test_random();
    test_round_robin();
    test_backpressure();
    test_reset_midrun();
    test_width40();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
